feature_frame_assembler: RTL
============================

FEATURE_FRAME_ASSEMBLER -- requirements
Module: feature_frame_assembler

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL take parameter TOTAL_NUM_CHANNEL, default `TOTAL_NUM_CHANNEL (214), channels per feature frame.
REQ-003 SHALL take parameter CHANNEL_WIDTH, default `CHANNEL_WIDTH (2), bits per channel sample.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 sample_data  input  CHANNEL_WIDTH  one channel sample.
REQ-007 sample_first  input  1  marks sample as channel 0 of a frame.
REQ-008 sample_valid / sample_ready  input / output  1 each  sample handshake.
REQ-009 features_top  output  TOTAL_NUM_CHANNEL*CHANNEL_WIDTH  assembled frame to fusion core.
REQ-010 fin_valid / fin_ready  output / input  1 each  frame handshake toward fusion core.
REQ-011 frames_sent  output  16  count of frames accepted by core, wraps at 65535->0.
REQ-012 frame_errors  output  8  framing error count, saturates at 255.

Function
REQ-013 Transfer SHALL occur on a rising edge where valid and ready are both high, on either interface.
REQ-014 Channel index idx SHALL count 0..TOTAL_NUM_CHANNEL-1; accepted sample SHALL be written to features slice [idx*CHANNEL_WIDTH +: CHANNEL_WIDTH] (channel 0 at LSBs).
REQ-015 Two storage stages SHALL exist: assembly register and output register; features_top SHALL be driven only from the output register.
REQ-016 State machine SHALL have states FILL and HOLD; reset state FILL.
REQ-017 FILL: sample_ready=1; accepting sample at idx=TOTAL_NUM_CHANNEL-1 SHALL complete frame and reset idx to 0.
REQ-018 On completion, if output register empty or draining same cycle (fin_valid&&fin_ready), frame SHALL load into output register and fin_valid SHALL be 1 the next cycle; latency last sample -> fin_valid = 1 cycle; stay FILL.
REQ-019 Otherwise SHALL enter HOLD with completed frame retained in assembly register.
REQ-020 HOLD: sample_ready=0; on fin_valid&&fin_ready SHALL move assembly frame to output register, keep fin_valid=1, return to FILL.
REQ-021 Sustained throughput SHALL be one sample per cycle when core accepts each frame within TOTAL_NUM_CHANNEL cycles.
REQ-022 fin_valid SHALL stay high and features_top stable until handshake; SHALL drop the cycle after handshake unless a new frame loads simultaneously.
REQ-023 sample_first=1 accepted at idx!=0 SHALL discard partial frame, increment frame_errors, and store sample as channel 0 (idx becomes 1).
REQ-024 sample_first=0 accepted at idx=0 SHALL drop the sample, increment frame_errors, idx stays 0.
REQ-025 frames_sent SHALL increment on each fin handshake.
REQ-026 Assembly-register slices not yet written in the current frame SHALL hold stale data; only full frames SHALL ever reach the output register.
REQ-027 sample_ready SHALL depend only on state (no combinational path from fin_ready).

Reset
REQ-028 On rst low: fin_valid=0, sample_ready=0 during reset, features_top=0, frames_sent=0, frame_errors=0, idx=0, state FILL.
REQ-029 Reset mid-frame or with fin_valid high SHALL discard all frames without handshake; sample_ready=1 first cycle after release.

Structure
REQ-030 CHANNEL_WIDTH, TOTAL_NUM_CHANNEL, state enum, and counter widths SHALL come from shared package hdc_pkg (macros remain in const.vh).
REQ-031 One sub-module feature_frame_counter (index counter with first-sample resync) is natural; all else inline.

Verification (bench with TOTAL_NUM_CHANNEL=4, CHANNEL_WIDTH=2)
REQ-032 Samples 1,2,3,0 (first on 1), fin_ready=1 -> fin_valid one cycle after 4th sample, features_top=8'b00_11_10_01, frames_sent=1.
REQ-033 Two frames back-to-back, fin_ready=0 -> after 2nd frame completes, sample_ready=0 (HOLD); fin_ready=1 pulse -> frame1 out, then frame2, sample_ready=1.
REQ-034 sample_first at idx=2 -> frame_errors=1, new frame built from that sample; no partial frame emitted.
REQ-035 First sample without sample_first -> dropped, frame_errors=1, idx=0; 300 such -> frame_errors=255.
REQ-036 rst low while fin_valid=1 and idx=2 -> fin_valid=0, counters 0; next complete frame emitted correctly.
REQ-037 Random valid/ready gaps (0-15 cycles), 380 frames -> all frames match golden in order, frames_sent=380, frame_errors=0.

Source files
------------

// File: rtl/hdc_pkg.sv
// hdc_pkg: shared frame geometry, counter widths and assembler state encoding.
package hdc_pkg;

   localparam int TOTAL_NUM_CHANNEL = 214;
   localparam int CHANNEL_WIDTH     = 2;
   localparam int FRAMES_W          = 16;
   localparam int ERRORS_W          = 8;

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} asm_state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/feature_frame_counter.sv
// feature_frame_counter: channel index tracking with resync on sample_first.
module feature_frame_counter
   import hdc_pkg::*;
#(
   parameter int N  = TOTAL_NUM_CHANNEL,
   parameter int IW = idx_width(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          accept,
   input  logic          first,
   output logic [IW-1:0] idx,
   output logic [IW-1:0] wr_idx,
   output logic          wr_en,
   output logic          done,
   output logic          err
);

   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [IW-1:0] idx_q, idx_d;

   assign idx = idx_q;

   always_ff @(posedge clk or negedge rst)
      if (!rst) idx_q <= '0;
      else      idx_q <= idx_d;

   // A first-flagged sample always restarts the frame; an unflagged one at idx 0 is dropped.
   always_comb begin
      idx_d  = idx_q;
      wr_idx = idx_q;
      wr_en  = 1'b0;
      done   = 1'b0;
      err    = 1'b0;
      if (accept) begin
         if (first) begin
            err    = idx_q != '0;
            wr_en  = 1'b1;
            wr_idx = '0;
            done   = N == 1;
            idx_d  = (N == 1) ? '0 : IW'(1);
         end else if (idx_q == '0) begin
            err = 1'b1;
         end else begin
            wr_en = 1'b1;
            done  = idx_q == LAST;
            idx_d = done ? '0 : idx_q + IW'(1);
         end
      end
   end

endmodule

// File: rtl/feature_frame_assembler.sv
// feature_frame_assembler: packs channel samples into frames and hands them to the fusion core
// through a two-stage (assembly + output) register pair.
module feature_frame_assembler #(
   parameter int TOTAL_NUM_CHANNEL = hdc_pkg::TOTAL_NUM_CHANNEL,
   parameter int CHANNEL_WIDTH     = hdc_pkg::CHANNEL_WIDTH
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [CHANNEL_WIDTH-1:0]                   sample_data,
   input  logic                                       sample_first,
   input  logic                                       sample_valid,
   output logic                                       sample_ready,
   output logic [TOTAL_NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
   output logic                                       fin_valid,
   input  logic                                       fin_ready,
   output logic [hdc_pkg::FRAMES_W-1:0]               frames_sent,
   output logic [hdc_pkg::ERRORS_W-1:0]               frame_errors
);

   import hdc_pkg::*;

   localparam int FW = TOTAL_NUM_CHANNEL * CHANNEL_WIDTH;
   localparam int IW = idx_width(TOTAL_NUM_CHANNEL);

   asm_state_e          state_q, state_d;
   logic [FW-1:0]       asm_q, asm_d, out_q, out_d;
   logic                fin_valid_q, fin_valid_d;
   logic [FRAMES_W-1:0] sent_q, sent_d;
   logic [ERRORS_W-1:0] err_q, err_d;
   logic                accept, fin_fire, wr_en, done, err, load_asm, load_hold;
   logic [IW-1:0]       idx, wr_idx;

   // Gating with rst keeps ready low while reset is held without involving fin_ready.
   assign sample_ready = rst && state_q == FILL;
   assign accept       = sample_valid && sample_ready;
   assign fin_fire     = fin_valid_q && fin_ready;
   assign features_top = out_q;
   assign fin_valid    = fin_valid_q;
   assign frames_sent  = sent_q;
   assign frame_errors = err_q;

   feature_frame_counter #(.N(TOTAL_NUM_CHANNEL), .IW(IW)) u_counter (
      .clk    (clk),
      .rst    (rst),
      .accept (accept),
      .first  (sample_first),
      .idx    (idx),
      .wr_idx (wr_idx),
      .wr_en  (wr_en),
      .done   (done),
      .err    (err)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst) state_q <= FILL;
      else      state_q <= state_d;

   always_comb begin
      state_d = state_q;
      if (state_q == FILL && done && fin_valid_q && !fin_ready) state_d = HOLD;
      if (state_q == HOLD && fin_fire)                          state_d = FILL;
   end

   // A completed frame bypasses HOLD when the output register is free or draining this cycle.
   always_comb begin
      load_asm  = state_q == FILL && done && (!fin_valid_q || fin_fire);
      load_hold = state_q == HOLD && fin_fire;
      asm_d     = asm_q;
      if (wr_en) asm_d[wr_idx*CHANNEL_WIDTH +: CHANNEL_WIDTH] = sample_data;
      out_d       = load_asm ? asm_d : load_hold ? asm_q : out_q;
      fin_valid_d = load_asm || load_hold || (fin_valid_q && !fin_ready);
      sent_d      = fin_fire ? sent_q + FRAMES_W'(1) : sent_q;
      err_d       = (err && err_q != '1) ? err_q + ERRORS_W'(1) : err_q;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         asm_q       <= '0;
         out_q       <= '0;
         fin_valid_q <= 1'b0;
         sent_q      <= '0;
         err_q       <= '0;
      end else begin
         asm_q       <= asm_d;
         out_q       <= out_d;
         fin_valid_q <= fin_valid_d;
         sent_q      <= sent_d;
         err_q       <= err_d;
      end

endmodule
